// File: rtl/bp_be_dual_issue_queue_if.sv
// Enqueue/dequeue bundle of the dual-issue queue; master drives requests, slave returns state.
// Every slave output is taken from registered state, so a request never combinationally affects it.
interface bp_be_dual_issue_queue_if #(
    parameter int els_p   = 6,
    parameter int width_p = 64
);
    localparam int cnt_width_lp = $clog2(els_p + 1);

    logic [1:0]                  enq_cnt_i;
    logic [1:0][width_p-1:0]     enq_data_i;
    logic                        enq_ready_o;
    logic [cnt_width_lp-1:0]     free_o;
    logic [1:0]                  deq_cnt_i;
    logic [1:0][width_p-1:0]     deq_data_o;
    logic [1:0]                  deq_v_o;
    logic [cnt_width_lp-1:0]     count_o;
    logic                        err_o;

    modport master (
        output enq_cnt_i, enq_data_i, deq_cnt_i,
        input  enq_ready_o, free_o, deq_data_o, deq_v_o, count_o, err_o
    );

    modport slave (
        input  enq_cnt_i, enq_data_i, deq_cnt_i,
        output enq_ready_o, free_o, deq_data_o, deq_v_o, count_o, err_o
    );
endinterface

// File: rtl/bp_be_dual_issue_queue.sv
// Circular queue, 0-2 enqueues and 0-2 dequeues per cycle; entries visible one cycle after enqueue.
// Requests exceeding free slots / occupancy are dropped and set a sticky error instead of stalling.
module bp_be_dual_issue_queue #(
    parameter int els_p            = 6,
    parameter int width_p          = 64,
    parameter bit report_illegal_p = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_i,
    bp_be_dual_issue_queue_if.slave q
);
    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_width_lp = $clog2(els_p + 1);
    localparam logic [ptr_width_lp:0]   els_lp  = (ptr_width_lp + 1)'(els_p);
    localparam logic [cnt_width_lp-1:0] els_cnt = cnt_width_lp'(els_p);

    typedef logic [ptr_width_lp-1:0] ptr_t;

    // Wrapped and unwrapped sums are formed side by side; the sign of the wrapped one picks.
    function automatic ptr_t wrap_add(input ptr_t ptr, input logic [1:0] add);
        logic [ptr_width_lp:0] w;
        logic [ptr_width_lp:0] nw;
        w  = {1'b0, ptr} - els_lp + (ptr_width_lp + 1)'(add);
        nw = {1'b0, ptr} + (ptr_width_lp + 1)'(add);
        return w[ptr_width_lp] ? nw[ptr_width_lp-1:0] : w[ptr_width_lp-1:0];
    endfunction

    logic [width_p-1:0]      r_mem [els_p];
    ptr_t                    r_head;
    ptr_t                    r_tail;
    logic [cnt_width_lp-1:0] r_count;
    logic                    r_err;

    logic [cnt_width_lp-1:0] w_free;
    logic                    w_enq_ok;
    logic                    w_deq_ok;
    logic [1:0]              w_enq_acc;
    logic [1:0]              w_deq_acc;
    ptr_t                    w_head_p1;
    ptr_t                    w_tail_p1;

    assign w_free    = els_cnt - r_count;
    assign w_enq_ok  = (q.enq_cnt_i != 2'd3) && (cnt_width_lp'(q.enq_cnt_i) <= w_free);
    assign w_deq_ok  = (q.deq_cnt_i != 2'd3) && (cnt_width_lp'(q.deq_cnt_i) <= r_count);
    assign w_enq_acc = w_enq_ok ? q.enq_cnt_i : 2'd0;
    assign w_deq_acc = w_deq_ok ? q.deq_cnt_i : 2'd0;
    assign w_head_p1 = wrap_add(r_head, 2'd1);
    assign w_tail_p1 = wrap_add(r_tail, 2'd1);

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_head  <= wrap_add(r_head, w_deq_acc);
            r_tail  <= wrap_add(r_tail, w_enq_acc);
            r_count <= r_count + cnt_width_lp'(w_enq_acc) - cnt_width_lp'(w_deq_acc);
            if (!w_enq_ok || !w_deq_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    // Storage is deliberately left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset_i && w_enq_acc != 2'd0) begin
            r_mem[r_tail] <= q.enq_data_i[0];
        end
        if (!reset_i && w_enq_acc == 2'd2) begin
            r_mem[w_tail_p1] <= q.enq_data_i[1];
        end
    end

    assign q.count_o       = r_count;
    assign q.free_o        = w_free;
    assign q.enq_ready_o   = (w_free >= cnt_width_lp'(2));
    assign q.deq_v_o       = {(r_count > cnt_width_lp'(1)), (r_count != '0)};
    assign q.deq_data_o[0] = r_mem[r_head];
    assign q.deq_data_o[1] = r_mem[w_head_p1];
    assign q.err_o         = r_err;

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            assert (r_count <= els_cnt) else $error("queue count overflow");
            assert ({1'b0, r_head} < els_lp && {1'b0, r_tail} < els_lp)
                else $error("queue pointer out of range");
            assert (!report_illegal_p || (w_enq_ok && w_deq_ok))
                else $error("illegal enqueue/dequeue request");
        end
    end
endmodule

// File: tb/tb_bp_be_dual_issue_queue.sv
// Directed bench for bp_be_dual_issue_queue (els_p = 6): stimulus queues expected post-edge state,
// a negedge monitor pops and compares against the DUT outputs.
module tb_bp_be_dual_issue_queue;
    localparam int ELS = 6;
    localparam int W   = 64;

    localparam logic [W-1:0] A  = 64'h0000_0000_0000_0A0A;
    localparam logic [W-1:0] B  = 64'h0000_0000_0000_0B0B;
    localparam logic [W-1:0] C  = 64'h1111_2222_3333_4444;
    localparam logic [W-1:0] D  = 64'h5555_6666_7777_8888;
    localparam logic [W-1:0] E  = 64'h0E0E_0E0E_0E0E_0E0E;
    localparam logic [W-1:0] F  = 64'hFFFF_0000_FFFF_0000;
    localparam logic [W-1:0] G  = 64'h0000_FFFF_0000_FFFF;
    localparam logic [W-1:0] P  = 64'h0000_0000_0000_00F0;
    localparam logic [W-1:0] Q  = 64'h0000_0000_0000_00F1;
    localparam logic [W-1:0] H0 = 64'hC0C0_0000_0000_0000;
    localparam logic [W-1:0] H1 = 64'hC0C0_0000_0000_0001;
    localparam logic [W-1:0] H2 = 64'hC0C0_0000_0000_0002;
    localparam logic [W-1:0] H3 = 64'hC0C0_0000_0000_0003;
    localparam logic [W-1:0] H4 = 64'hC0C0_0000_0000_0004;
    localparam logic [W-1:0] H5 = 64'hC0C0_0000_0000_0005;
    localparam logic [W-1:0] X  = 64'hDEAD_DEAD_DEAD_DEAD;
    localparam logic [W-1:0] Y  = 64'hBAD0_BAD0_BAD0_BAD0;
    localparam logic [W-1:0] Z  = 64'hBAD1_BAD1_BAD1_BAD1;
    localparam logic [W-1:0] R  = 64'h1234_5678_9ABC_DEF0;
    localparam logic [W-1:0] S  = 64'h0FED_CBA9_8765_4321;
    localparam logic [W-1:0] T  = 64'h7777_7777_0000_0001;
    localparam logic [W-1:0] U  = 64'h9999_9999_9999_9999;
    localparam logic [W-1:0] V  = 64'h8888_8888_8888_8888;
    localparam logic [W-1:0] NA = 64'h0;

    typedef struct {
        string        name;
        logic [2:0]   cnt;
        logic [1:0]   v;
        logic [2:0]   free;
        logic         rdy;
        logic         err;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
    } exp_t;

    logic clk;
    logic reset_i;
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec;
    int   n_bad;

    bp_be_dual_issue_queue_if #(.els_p(ELS), .width_p(W)) qif ();

    bp_be_dual_issue_queue #(
        .els_p(ELS), .width_p(W), .report_illegal_p(1'b0)
    ) dut (
        .clk(clk),
        .reset_i(reset_i),
        .q(qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string nm, input logic [2:0] c, input logic [1:0] v,
                            input logic er, input logic [W-1:0] x0, input logic [W-1:0] x1);
        exp_t e;
        e.name = nm;
        e.cnt  = c;
        e.v    = v;
        e.free = 3'(ELS) - c;
        e.rdy  = ((3'(ELS) - c) >= 3'd2);
        e.err  = er;
        e.d0   = x0;
        e.d1   = x1;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of requests; the expectation describes the state after that edge.
    task automatic step(input string nm, input logic [1:0] enq, input logic [W-1:0] a0,
                        input logic [W-1:0] a1, input logic [1:0] deq, input logic [2:0] c,
                        input logic [1:0] v, input logic er, input logic [W-1:0] x0,
                        input logic [W-1:0] x1);
        qif.enq_cnt_i     = enq;
        qif.enq_data_i[0] = a0;
        qif.enq_data_i[1] = a1;
        qif.deq_cnt_i     = deq;
        @(posedge clk);
        #1;
        push_exp(nm, c, v, er, x0, x1);
        qif.enq_cnt_i  = 2'd0;
        qif.deq_cnt_i  = 2'd0;
        qif.enq_data_i = '0;
    endtask

    task automatic check(input exp_t e);
        logic bad;
        n_vec++;
        bad = (qif.count_o != e.cnt) || (qif.deq_v_o != e.v) || (qif.free_o != e.free) ||
              (qif.enq_ready_o != e.rdy) || (qif.err_o != e.err) ||
              (e.v[0] && qif.deq_data_o[0] !== e.d0) || (e.v[1] && qif.deq_data_o[1] !== e.d1);
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got cnt=%0d v=%b free=%0d rdy=%b err=%b d0=%h d1=%h; want cnt=%0d v=%b free=%0d rdy=%b err=%b d0=%h d1=%h",
                     e.name, qif.count_o, qif.deq_v_o, qif.free_o, qif.enq_ready_o, qif.err_o,
                     qif.deq_data_o[0], qif.deq_data_o[1], e.cnt, e.v, e.free, e.rdy, e.err,
                     e.d0, e.d1);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check(mon_e);
        end
    end

    initial begin
        n_vec          = 0;
        n_bad          = 0;
        reset_i        = 1'b1;
        qif.enq_cnt_i  = 2'd0;
        qif.deq_cnt_i  = 2'd0;
        qif.enq_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        push_exp("reset", 3'd0, 2'b00, 1'b0, NA, NA);

        step("enq2_ab",     2'd2, A,  B,  2'd0, 3'd2, 2'b11, 1'b0, A,  B);
        step("drain_ab",    2'd0, NA, NA, 2'd2, 3'd0, 2'b00, 1'b0, NA, NA);
        step("enq2_cd",     2'd2, C,  D,  2'd0, 3'd2, 2'b11, 1'b0, C,  D);
        step("drain_cd",    2'd0, NA, NA, 2'd2, 3'd0, 2'b00, 1'b0, NA, NA);
        step("enq1_e",      2'd1, E,  NA, 2'd0, 3'd1, 2'b01, 1'b0, E,  NA);
        step("deq1_e",      2'd0, NA, NA, 2'd1, 3'd0, 2'b00, 1'b0, NA, NA);
        step("wrap_enq2",   2'd2, F,  G,  2'd0, 3'd2, 2'b11, 1'b0, F,  G);
        step("wrap_deq2",   2'd0, NA, NA, 2'd2, 3'd0, 2'b00, 1'b0, NA, NA);
        step("enq1_p",      2'd1, P,  NA, 2'd0, 3'd1, 2'b01, 1'b0, P,  NA);
        step("enq1_deq1",   2'd1, Q,  NA, 2'd1, 3'd1, 2'b01, 1'b0, Q,  NA);
        step("deq1_q",      2'd0, NA, NA, 2'd1, 3'd0, 2'b00, 1'b0, NA, NA);
        step("fill_01",     2'd2, H0, H1, 2'd0, 3'd2, 2'b11, 1'b0, H0, H1);
        step("fill_23",     2'd2, H2, H3, 2'd0, 3'd4, 2'b11, 1'b0, H0, H1);
        step("fill_45",     2'd2, H4, H5, 2'd0, 3'd6, 2'b11, 1'b0, H0, H1);
        step("ovf_enq1",    2'd1, X,  NA, 2'd0, 3'd6, 2'b11, 1'b1, H0, H1);
        step("full_2x2",    2'd2, Y,  Z,  2'd2, 3'd4, 2'b11, 1'b1, H2, H3);
        step("deq2_h45",    2'd0, NA, NA, 2'd2, 3'd2, 2'b11, 1'b1, H4, H5);
        step("deq1_h4",     2'd0, NA, NA, 2'd1, 3'd1, 2'b01, 1'b1, H5, NA);
        step("udf_deq2",    2'd0, NA, NA, 2'd2, 3'd1, 2'b01, 1'b1, H5, NA);
        step("enq2_rs",     2'd2, R,  S,  2'd0, 3'd3, 2'b11, 1'b1, H5, R);

        // Pulse reset between edges; no clock edge falls inside the pulse.
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        #2;
        reset_i = 1'b0;
        push_exp("async_reset", 3'd0, 2'b00, 1'b0, NA, NA);

        step("post_rst_enq", 2'd1, T, NA, 2'd0, 3'd1, 2'b01, 1'b0, T, NA);
        step("enq3_illegal", 2'd3, U, V,  2'd0, 3'd1, 2'b01, 1'b1, T, NA);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bp_be_dual_issue_queue.md
Name: bp_be_dual_issue_queue

Overview:
Circular instruction/operand queue feeding the dual-issue checker. Enqueues 0–2 entries and dequeues 0–2 entries per cycle. Head and tail pointers advance modulo els_p, which need not be a power of two. Wrap handling uses the same wrapped/non-wrapped parallel-compute scheme as the checker's circular pointers.

Parameters:
els_p, 6, number of storage slots; must be >= 2; non-power-of-two is legal.
width_p, 64, bits per entry.
ptr_width_lp, BSG_SAFE_CLOG2(els_p), head/tail pointer width (local).
cnt_width_lp, $clog2(els_p+1), occupancy count width (local).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_i  in  1  asynchronous, active-high reset.
enq_cnt_i  in  2  number of entries to enqueue this cycle (0..2). The value 3 is illegal.
enq_data_i  in  2*width_p  slot [0] is written first, then slot [1].
enq_ready_o  out  1  asserted when free slots >= 2.
free_o  out  cnt_width_lp  free slots, from registered state.
deq_cnt_i  in  2  number of entries to dequeue this cycle (0..2).
deq_data_o  out  2*width_p  [0] = head entry, [1] = head+1 entry (modulo els_p).
deq_v_o  out  2  bit k set when count > k.
count_o  out  cnt_width_lp  current occupancy.
err_o  out  1  sticky error flag; set on an illegal enqueue or dequeue.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - head = tail = 0, count = 0, err_o = 0.
  - Outputs: deq_v_o = 0, free_o = els_p, enq_ready_o = 1.
  - Storage contents are not reset.
- State:
  - head_r, tail_r, count_r, err_r, plus the mem array.
  - No FSM beyond these counters.
  - All outputs depend only on registered state, never on same-cycle inputs.
- Enqueue:
  - Legal when enq_cnt_i <= free_o and enq_cnt_i != 3.
  - Legal case: writes enq_data_i[0] to mem[tail]. If enq_cnt_i == 2, also writes enq_data_i[1] to mem[(tail+1) mod els_p].
  - tail_n = (tail + enq_cnt_i) mod els_p.
  - Illegal case: no entries are written, tail holds, err_r is set to 1.
- Dequeue:
  - Legal when deq_cnt_i <= count_r and deq_cnt_i != 3.
  - Legal case: head_n = (head + deq_cnt_i) mod els_p.
  - Illegal case: head holds and err_r is set.
- Wrap arithmetic:
  - Compute w = {1'b0, ptr} - els_p + add and nw = ptr + add in parallel.
  - Result = w when the sign bit of w is 0, else nw.
  - Must be correct at every ptr in [0, els_p-1] with add in [0, 2].
- Count:
  - count_n = count_r + accepted_enq - accepted_deq.
  - The invariant 0 <= count <= els_p always holds.
- Simultaneous enqueue and dequeue:
  - Legality of each is judged against pre-cycle state only.
  - A full queue with deq_cnt_i = 2 and enq_cnt_i = 2 rejects the enqueue (free_o = 0) and accepts the dequeue.
  - No bypass: an enqueued entry is visible on deq_data_o no earlier than the next cycle.
- Read ports:
  - deq_data_o[1] is read from (head+1) mod els_p.
  - When deq_v_o[k] = 0, deq_data_o[k] is don't-care.
- Reset mid-operation: all in-flight state is discarded asynchronously. The first edge after reset deasserts behaves as an empty queue.
- err_o clears only on reset.
- Simulation assertions:
  - count_r <= els_p.
  - head_r < els_p and tail_r < els_p.
  - An illegal request raises $error (suppressed while reset_i = 1).

Test Plan:
1. Reset, then enq_cnt_i = 2 with data {B, A} -> next cycle count_o = 2, deq_v_o = 2'b11, deq_data_o = {B, A}, free_o = 4.
2. Wrap, els_p = 6: from head = tail = 5, count = 0, enqueue 2 -> tail = 1. Dequeue 2 -> head = 1, data returned in order; then count_o = 0, deq_v_o = 0.
3. Fill to 6 entries, then enq_cnt_i = 1 -> err_o = 1, count_o stays 6, tail unchanged, contents intact.
4. Full queue, enq_cnt_i = 2 with deq_cnt_i = 2 in the same cycle -> enqueue rejected with err_o set, count_o = 4, head advanced by 2.
5. count = 1, enq_cnt_i = 1 with deq_cnt_i = 1 -> count_o stays 1, deq_data_o[0] = the new entry the next cycle, no error.
6. Assert reset_i asynchronously mid-cycle with count = 3 -> count_o = 0, deq_v_o = 0, free_o = 6, enq_ready_o = 1 immediately, err_o = 0.
